// File: rtl/lda_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lda_cmd_sequencer: FIFO-buffered go/done initiator for the line-drawing engine.
// Optional watchdog: define LDA_CMD_SEQUENCER_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module lda_cmd_sequencer #(
  parameter int DEPTH          = 4,
  parameter int COLOR_W        = 3,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 131072
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [8:0]         cmd_x0,
  input  logic [7:0]         cmd_y0,
  input  logic [8:0]         cmd_x1,
  input  logic [7:0]         cmd_y1,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               flush,
  output logic               lda_go,
  output logic [8:0]         lda_x0,
  output logic [7:0]         lda_y0,
  output logic [8:0]         lda_x1,
  output logic [7:0]         lda_y1,
  output logic [COLOR_W-1:0] lda_color,
  input  logic               lda_done,
  output logic               busy,
  output logic [CNT_W-1:0]   lines_done,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = 34 + COLOR_W;
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_DONE    = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   count_q;
  logic               push, pop, to_hit;
  logic [ENT_W-1:0]   eng_q;
  logic [CNT_W-1:0]   lines_done_q;

  assign cmd_ready = (count_q != FULL_CNT);
  assign push      = cmd_valid & cmd_ready & ~flush;

  // Storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((count_q != '0) && !flush) begin
          pop     = 1'b1;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE:    if (lda_done || to_hit) state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (!lda_done) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Engine-side operands latch only on the pop and then hold indefinitely.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  eng_q <= '0;
    else if (pop)  eng_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                               lines_done_q <= '0;
    else if ((state_q == WAIT_DONE) && lda_done) lines_done_q <= lines_done_q + 1'b1;
  end

`ifdef LDA_CMD_SEQUENCER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_err_q;

  assign to_hit = (state_q == WAIT_DONE) && !lda_done &&
                  (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                    to_cnt_q <= '0;
    else if (pop)                    to_cnt_q <= '0;
    else if (state_q == WAIT_DONE)   to_cnt_q <= to_cnt_q + 1'b1;
  end

  // A timeout on the same edge as err_clr leaves the error set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     timeout_err_q <= 1'b0;
    else if (to_hit)  timeout_err_q <= 1'b1;
    else if (err_clr) timeout_err_q <= 1'b0;
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_cfg;
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
  assign unused_cfg  = err_clr ^ (TIMEOUT_CYCLES == 0);
`endif

  assign lda_go     = (state_q == WAIT_DONE);
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign lines_done = lines_done_q;
  assign {lda_x0, lda_y0, lda_x1, lda_y1, lda_color} = eng_q;

endmodule
`default_nettype wire

// File: tb/tb_lda_cmd_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lda_cmd_sequencer: scoreboard bench for lda_cmd_sequencer.  Rev 1.0
// ----------------------------------------------------------------------------
module tb_lda_cmd_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0, flush = 1'b0, lda_done = 1'b0, err_clr = 1'b0;
  logic        cmd_ready, lda_go, busy, timeout_err;
  logic [8:0]  cmd_x0 = '0, cmd_x1 = '0, lda_x0, lda_x1;
  logic [7:0]  cmd_y0 = '0, cmd_y1 = '0, lda_y0, lda_y1;
  logic [2:0]  cmd_color = '0, lda_color;
  logic [15:0] lines_done;

  typedef struct packed {
    logic [8:0] x0;
    logic [7:0] y0;
    logic [8:0] x1;
    logic [7:0] y1;
    logic [2:0] c;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   eng_auto = 1'b0;
  int   eng_delay = 4;
  int   eng_hold = 1;

  always #5 clock = ~clock;

  lda_cmd_sequencer #(.DEPTH(4), .COLOR_W(3), .CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .flush(flush),
    .lda_go(lda_go), .lda_x0(lda_x0), .lda_y0(lda_y0), .lda_x1(lda_x1), .lda_y1(lda_y1),
    .lda_color(lda_color), .lda_done(lda_done),
    .busy(busy), .lines_done(lines_done), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input cmd_t c);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color} = c;
    for (int t = 0; t < 300 && !ok; t++) begin
      ok = cmd_ready;
      @(negedge clock);
    end
    cmd_valid = 1'b0;
    if (ok) exp_q.push_back(c);
    else chk("push_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int t = 0; t < budget && !done; t++) begin
      @(negedge clock);
      done = !busy && (exp_q.size() == 0) && !lda_done;
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  // Monitor: every rising go is one issued line, compared against the queue head.
  initial begin
    cmd_t cur, e;
    logic go_prev = 1'b0;
    cur = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        go_prev = 1'b0;
      end else begin
        if (lda_go && !go_prev) begin
          cur = {lda_x0, lda_y0, lda_x1, lda_y1, lda_color};
          if (exp_q.size() == 0) chk("unexpected_go", {27'd0, cur}, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("line_issue", {27'd0, cur}, {27'd0, e});
          end
        end
        if (!lda_go && go_prev)
          chk("held_after_line", {27'd0, lda_x0, lda_y0, lda_x1, lda_y1, lda_color}, {27'd0, cur});
        go_prev = lda_go;
      end
    end
  end

  // Engine model used when eng_auto is set: done after eng_delay go-cycles, held eng_hold cycles.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clock);
      if (eng_auto) begin
        if (lda_go && !lda_done) begin
          cnt++;
          if (cnt >= eng_delay) begin lda_done = 1'b1; cnt = 0; end
        end else if (!lda_go && lda_done) begin
          if (cnt >= eng_hold) begin lda_done = 1'b0; cnt = 0; end
          else cnt++;
        end else cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_go", lda_go, 0);
    chk("rst_lines", lines_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_x0", lda_x0, 0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst", cmd_ready, 1);

    // Single line, done after 91 go-cycles
    push('{9'd10, 8'd20, 9'd100, 8'd50, 3'd5});
    chk("go_before_pop", lda_go, 0);
    chk("busy_queued", busy, 1);
    @(negedge clock);
    chk("go_one_after_accept", lda_go, 1);
    repeat (90) @(negedge clock);
    lda_done = 1'b1;
    chk("go_held_wait", lda_go, 1);
    @(negedge clock);
    chk("go_falls_on_done", lda_go, 0);
    chk("lines_after_1", lines_done, 1);
    @(negedge clock);
    lda_done = 1'b0;
    @(negedge clock);
    chk("busy_idle_1", busy, 0);
    chk("x0_held", lda_x0, 10);
    chk("color_held", lda_color, 5);

    // Done held 3 cycles after go falls delays the next line
    push('{9'd1, 8'd2, 9'd3, 8'd4, 3'd1});
    @(negedge clock);
    chk("go_A", lda_go, 1);
    push('{9'd5, 8'd6, 9'd7, 8'd8, 3'd2});
    lda_done = 1'b1;
    @(negedge clock);
    chk("go_A_falls", lda_go, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("no_go_while_done", lda_go, 0);
    end
    lda_done = 1'b0;
    @(negedge clock);
    chk("no_go_release_cycle", lda_go, 0);
    @(negedge clock);
    chk("go_B", lda_go, 1);
    lda_done = 1'b1;
    @(negedge clock);
    lda_done = 1'b0;
    wait_idle(20);
    chk("lines_after_3", lines_done, 3);
    lda_done = 1'b1;
    repeat (3) @(negedge clock);
    chk("stale_done_lines", lines_done, 3);
    chk("stale_done_go", lda_go, 0);
    lda_done = 1'b0;
    @(negedge clock);

    // Fill the FIFO while the engine stalls
    for (int i = 0; i < 5; i++) begin
      push('{9'(20 + i), 8'(40 + i), 9'(300 + i), 8'(200 + i), 3'(i + 2)});
      if (i == 3) chk("ready_after_4th", cmd_ready, 1);
      if (i == 4) chk("ready_after_5th", cmd_ready, 0);
    end
    repeat (3) @(negedge clock);
    chk("x0_stable_stall", lda_x0, 20);
    eng_delay = 4; eng_hold = 1; eng_auto = 1'b1;
    wait_idle(500);
    eng_auto = 1'b0;
    chk("lines_after_8", lines_done, 8);

    // Flush during line 1 with a simultaneous push
    push('{9'd111, 8'd11, 9'd222, 8'd22, 3'd3});
    push('{9'd112, 8'd12, 9'd223, 8'd23, 3'd4});
    push('{9'd113, 8'd13, 9'd224, 8'd24, 3'd6});
    flush = 1'b1;
    cmd_valid = 1'b1;
    {cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color} = {9'd400, 8'd99, 9'd401, 8'd98, 3'd7};
    @(negedge clock);
    flush = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    chk("flush_ready", cmd_ready, 1);
    chk("flush_inflight_go", lda_go, 1);
    lda_done = 1'b1;
    @(negedge clock);
    lda_done = 1'b0;
    chk("lines_after_flush", lines_done, 9);
    repeat (4) @(negedge clock);
    chk("flush_busy", busy, 0);
    chk("flush_no_go", lda_go, 0);

    // Asynchronous reset mid-line
    push('{9'd7, 8'd7, 9'd9, 8'd9, 3'd1});
    @(negedge clock);
    chk("go_before_reset", lda_go, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_go_drop", lda_go, 0);
    chk("async_lines_clr", lines_done, 0);
    chk("async_busy", busy, 0);
    chk("async_x0_clr", lda_x0, 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_rst2", cmd_ready, 1);
    eng_delay = 3; eng_hold = 0; eng_auto = 1'b1;
    push('{9'd8, 8'd8, 9'd10, 8'd10, 3'd2});
    wait_idle(100);
    eng_auto = 1'b0;
    chk("lines_after_rst2", lines_done, 1);

`ifdef LDA_CMD_SEQUENCER_TIMEOUT_EN
    // Watchdog: go drops after 16 cycles without done
    push('{9'd30, 8'd31, 9'd32, 8'd33, 3'd3});
    push('{9'd34, 8'd35, 9'd36, 8'd37, 3'd4});
    chk("to_go_up", lda_go, 1);
    n = 1;
    for (int t = 0; t < 100 && lda_go; t++) begin
      @(negedge clock);
      if (lda_go) n++;
    end
    chk("to_go_cycles", n, 16);
    chk("to_err_set", timeout_err, 1);
    chk("to_lines_same", lines_done, 1);
    eng_delay = 3; eng_hold = 0; eng_auto = 1'b1;
    wait_idle(100);
    eng_auto = 1'b0;
    chk("to_lines_next", lines_done, 2);
    chk("to_err_sticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("to_err_clr", timeout_err, 0);
`else
    // Without the watchdog a silent engine keeps go high indefinitely
    push('{9'd30, 8'd31, 9'd32, 8'd33, 3'd3});
    n = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (lda_go) n++;
    end
    chk("nto_go_held", n, 40);
    chk("nto_err_zero", timeout_err, 0);
    lda_done = 1'b1;
    @(negedge clock);
    lda_done = 1'b0;
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    wait_idle(20);
    chk("nto_lines", lines_done, 2);
    chk("nto_err_clr", timeout_err, 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
